// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, single baud counter, mid-bit sampling.
// Emits one-cycle valid / framingError pulses; data holds the last good byte.
module uart_rx #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framingError,
  output logic       busy
);

  localparam int D  = ClockFrequency / BaudRate;
  localparam int H  = D / 2;
  localparam int CW = $clog2(D) + 1;
  localparam logic [CW-1:0] DLast = CW'(D - 1);
  localparam logic [CW-1:0] HLast = CW'(H - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_n;
  logic          sync1, sync2, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n, data_n;
  logic          valid_n, fe_n;

  assign rxs  = sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      data         <= '0;
      valid        <= 1'b0;
      framingError <= 1'b0;
    end else begin
      sync1        <= rx;
      sync2        <= sync1;
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shreg        <= shreg_n;
      data         <= data_n;
      valid        <= valid_n;
      framingError <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data;
    valid_n = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // Mid-start-bit check rejects short glitches.
        if (cnt == HLast) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == DLast) begin
          cnt_n        = '0;
          shreg_n[idx] = rxs;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == DLast) begin
          cnt_n = '0;
          if (rxs) begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line reports once, then waits for the line to recover.
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one fast instance (D=16) and one at default rates (D=104),
// with a scoreboard of expected pulses (kind, data, cycle) checked by per-instance monitors.
module tb_uart_rx;

  typedef struct {
    logic       fe;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, fe_a, fe_b, busy_a, busy_b;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  uart_rx #(.ClockFrequency(16), .BaudRate(1)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .data(data_a),
    .valid(valid_a), .framingError(fe_a), .busy(busy_a));

  uart_rx dut_b (
    .clock(clock), .reset(reset), .rx(rx_b), .data(data_b),
    .valid(valid_b), .framingError(fe_b), .busy(busy_b));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitors: every pulse must match the head of its scoreboard queue.
  always @(negedge clock) begin
    if (valid_a || fe_a) begin
      tests++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL mon_a_unexpected valid=%b fe=%b data=%h cyc=%0d", valid_a, fe_a, data_a, cyc);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if ({valid_a, fe_a, data_a} !== {~e.fe, e.fe, e.d} || cyc != e.cyc) begin
          fails++;
          $display("FAIL mon_a_pulse got valid=%b fe=%b data=%h cyc=%0d want valid=%b fe=%b data=%h cyc=%0d",
                   valid_a, fe_a, data_a, cyc, ~e.fe, e.fe, e.d, e.cyc);
        end
      end
    end
    if (valid_b || fe_b) begin
      tests++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL mon_b_unexpected valid=%b fe=%b data=%h cyc=%0d", valid_b, fe_b, data_b, cyc);
      end else begin
        exp_t e;
        e = qb.pop_front();
        if ({valid_b, fe_b, data_b} !== {~e.fe, e.fe, e.d} || cyc != e.cyc) begin
          fails++;
          $display("FAIL mon_b_pulse got valid=%b fe=%b data=%h cyc=%0d want valid=%b fe=%b data=%h cyc=%0d",
                   valid_b, fe_b, data_b, cyc, ~e.fe, e.fe, e.d, e.cyc);
        end
      end
    end
  end

  // Drives one frame starting at a negedge; the first posedge after is e0.
  task automatic send(input bit sel, input logic [7:0] b, input int bl, input logic stopv);
    exp_t       e;
    logic [9:0] fr;
    fr    = {stopv, b, 1'b0};
    e.fe  = ~stopv;
    e.cyc = cyc + 1 + (sel ? 990 : 154);
    if (sel) begin
      if (stopv) last_b = b;
      e.d = last_b;
      qb.push_back(e);
    end else begin
      if (stopv) last_a = b;
      e.d = last_a;
      qa.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = fr[i];
      else     rx_a = fr[i];
      repeat (bl) @(negedge clock);
    end
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({data_a, valid_a, fe_a, busy_a} !== 11'h0) begin
      fails++;
      $display("FAIL reset_a got data=%h valid=%b fe=%b busy=%b want 00/0/0/0", data_a, valid_a, fe_a, busy_a);
    end
    tests++;
    if ({data_b, valid_b, fe_b, busy_b} !== 11'h0) begin
      fails++;
      $display("FAIL reset_b got data=%h valid=%b fe=%b busy=%b want 00/0/0/0", data_b, valid_b, fe_b, busy_b);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_frame;
    send(0, 8'hA5, 16, 1'b1);
    repeat (4) @(negedge clock);
    tests++;
    if (qa.size() != 0) begin
      fails++;
      $display("FAIL frame_a5_missing got pending=%0d want 0", qa.size());
    end
    tests++;
    if (data_a !== 8'hA5 || busy_a !== 1'b0) begin
      fails++;
      $display("FAIL frame_a5_after got data=%h busy=%b want a5/0", data_a, busy_a);
    end
  endtask

  task automatic test_glitch;
    int nb;
    nb = 0;
    rx_a = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 5) rx_a = 1'b1;
      if (busy_a) nb++;
    end
    tests++;
    if (nb != 8) begin
      fails++;
      $display("FAIL glitch_busy got busy_cycles=%0d want 8", nb);
    end
    tests++;
    if (data_a !== 8'hA5 || qa.size() != 0) begin
      fails++;
      $display("FAIL glitch_data got data=%h pending=%0d want a5/0", data_a, qa.size());
    end
  endtask

  task automatic test_break;
    int r;
    send(0, 8'h3C, 16, 1'b0);
    repeat (84) @(negedge clock);
    rx_a = 1'b1;
    r = cyc;
    repeat (2) @(negedge clock);
    tests++;
    if (busy_a !== 1'b1) begin
      fails++;
      $display("FAIL break_busy_hold got busy=%b want 1 at cyc=%0d", busy_a, r + 2);
    end
    @(negedge clock);
    tests++;
    if (busy_a !== 1'b0) begin
      fails++;
      $display("FAIL break_busy_drop got busy=%b want 0 at cyc=%0d", busy_a, r + 3);
    end
    tests++;
    if (qa.size() != 0 || data_a !== 8'hA5) begin
      fails++;
      $display("FAIL break_result got pending=%0d data=%h want 0/a5", qa.size(), data_a);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    send(0, 8'h00, 16, 1'b1);
    send(0, 8'hFF, 16, 1'b1);
    repeat (4) @(negedge clock);
    tests++;
    if (qa.size() != 0 || data_a !== 8'hFF) begin
      fails++;
      $display("FAIL b2b_result got pending=%0d data=%h want 0/ff", qa.size(), data_a);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    b = 8'h55;
    rx_a = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx_a = b[i];
      repeat (16) @(negedge clock);
    end
    rx_a = b[4];
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({data_a, valid_a, fe_a, busy_a} !== 11'h0) begin
      fails++;
      $display("FAIL midreset_clear got data=%h valid=%b fe=%b busy=%b want 00/0/0/0", data_a, valid_a, fe_a, busy_a);
    end
    last_a = 8'h00;
    last_b = 8'h00;
    rx_a = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    tests++;
    if (busy_a !== 1'b0 || qa.size() != 0) begin
      fails++;
      $display("FAIL midreset_idle got busy=%b pending=%0d want 0/0", busy_a, qa.size());
    end
    send(0, 8'h81, 16, 1'b1);
    repeat (4) @(negedge clock);
    tests++;
    if (qa.size() != 0 || data_a !== 8'h81) begin
      fails++;
      $display("FAIL midreset_next got pending=%0d data=%h want 0/81", qa.size(), data_a);
    end
  endtask

  task automatic test_defaults;
    int bls[3];
    bls = '{104, 101, 107};
    foreach (bls[k]) begin
      send(1, 8'h5A, bls[k], 1'b1);
      repeat (20) @(negedge clock);
      tests++;
      if (qb.size() != 0 || data_b !== 8'h5A || busy_b !== 1'b0) begin
        fails++;
        $display("FAIL defaults_bit%0d got pending=%0d data=%h busy=%b want 0/5a/0",
                 bls[k], qb.size(), data_b, busy_b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_glitch;
    test_break;
    test_back_to_back;
    test_reset_midframe;
    test_defaults;
    repeat (10) @(negedge clock);
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL final_queues got a=%0d b=%0d want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter ClockFrequency, default 1000000, clock frequency in Hz.
REQ-002 Parameter BaudRate, default 9600, line rate in bit/s.
REQ-003 Derived constants: D = ClockFrequency/BaudRate (integer division, 104 at defaults); H = D/2 (integer, 52 at defaults); parameter sets giving D < 4 are unsupported.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 clock  input  1  clock, all state updates on rising edge.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 data  output  8  last correctly framed byte, held until next good frame.
REQ-008 valid  output  1  one-cycle pulse, data updated this cycle.
REQ-009 framingError  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); rxs = second flop; all decisions use rxs only.
REQ-012 A single counter (0..D-1) and a bit index (0..7) SHALL time all sampling; the counter clears on every state change.
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on rxs==0 -> START, counter=0; otherwise stay.
REQ-015 START: counter increments each cycle; at counter==H-1 sample rxs: 0 -> DATA (counter=0, index=0); 1 -> IDLE, no output pulse (glitch rejection).
REQ-016 DATA: counter increments; at counter==D-1 shift rxs into bit [index] of the shift register, counter=0, index+1; after index 7 is sampled -> STOP.
REQ-017 STOP: at counter==D-1 sample rxs: 1 -> data<=shift register, valid=1 for one cycle, -> IDLE; 0 -> framingError=1 for one cycle, data unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rxs==1, then -> IDLE; a held-low line (break) SHALL produce exactly one framingError.
REQ-019 valid and framingError SHALL never be high in the same cycle; each is high for exactly one cycle per frame.
REQ-020 Latency: if edge e0 is the first edge capturing rx==0 in sync flop 1, valid/framingError SHALL be high in the cycle following edge e0+2+H+9*D (990 cycles at defaults).
REQ-021 Back-to-back frames: a start bit arriving immediately after the stop-bit sample SHALL be received without loss (IDLE detects it on the following edge).
REQ-022 rx changes during START/DATA/STOP outside the sample points SHALL have no effect.
REQ-023 busy SHALL go high on the edge entering START and low on the edge entering IDLE.

Reset
REQ-024 On reset assertion, regardless of clock: state=IDLE, counter=0, index=0, shift register=0, data=8'h00, valid=0, framingError=0, busy=0, sync flops=1.
REQ-025 Reset mid-frame SHALL abandon the frame with no valid/framingError pulse; after release, reception restarts only on a new falling rxs.
REQ-026 If rx is low at reset release, the low SHALL be treated as a start bit (rxs goes low 2 edges after release).

Verification (ClockFrequency=16, BaudRate=1: D=16, H=8, unless noted)
REQ-027 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 clocks/bit -> valid pulse at cycle e0+154, data=8'hA5, framingError=0, busy low after.
REQ-028 rx low for 5 clocks, then high -> START rejects at sample, busy pulses ~8 cycles, no valid, no framingError, data unchanged.
REQ-029 Frame 0x3C with stop bit 0, rx then held low 100 clocks -> exactly one framingError pulse at e0+154, data keeps previous value, busy high until 2 cycles after rx returns high.
REQ-030 Two frames 0x00 and 0xFF back-to-back (no idle gap) -> two valid pulses 160 cycles apart, data 8'h00 then 8'hFF.
REQ-031 Reset asserted during bit 4 of frame 0x55 -> all outputs cleared immediately, no pulse; next frame 0x81 received correctly (data=8'h81).
REQ-032 Defaults (D=104): frame 0x5A, 104 clocks/bit -> valid at e0+990, data=8'h5A; repeat with bit period 101 and 107 clocks -> still data=8'h5A.
